// File: rtl/game_pkg.sv
// Shared encodings for the dino game state bus plus the packed-BCD score helpers.
// The state encodings are also used by the game-tick clock generator.
package game_pkg;

  typedef enum logic [1:0] {
    GAME_INIT  = 2'd0,
    GAME_START = 2'd1,
    GAME_END   = 2'd2,
    GAME_RESET = 2'd3
  } game_state_t;

  localparam int BCD_DIGIT_W  = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = BCD_DIGIT_W * SCORE_DIGITS;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  // Add one to a packed BCD value, rippling the carry from the ones digit upward.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] value);
    logic [SCORE_W-1:0] result;
    logic               carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (result[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
          result[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
        end else begin
          result[i*BCD_DIGIT_W +: BCD_DIGIT_W] = result[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed BCD counter: synchronous clear, enabled increment, saturates at 9999.
module bcd_counter4
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  // Score register; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != SCORE_MAX)) begin
      count <= bcd_inc(count);
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Master dino-game FSM: synchronizes the game tick, detects the start press,
// sequences INIT/START/END/RESET and keeps the running and high scores in BCD.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int TICKS_PER_POINT = 8,
  parameter int RESET_CYCLES    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_tick,
  input  logic               start_btn,
  input  logic               collision,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] score_bcd,
  output logic [SCORE_W-1:0] hi_score_bcd,
  output logic               new_record
);

  localparam int DIV_W  = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam int RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICKS_PER_POINT - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);

  game_state_t        state_r, state_s;
  logic               tick_sync1_r, tick_sync2_r, tick_prev_r, tick_rise_s;
  logic               btn_prev_r, start_pulse_s;
  logic [DIV_W-1:0]   div_r;
  logic [RCNT_W-1:0]  rcnt_r;
  logic               enter_reset_s, end_hit_s, tick_count_s, score_inc_s;
  logic               new_record_r;
  logic [SCORE_W-1:0] score_s, hi_score_r;

  // Tick synchronizer presets to 1 so a generator idling high gives no edge at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync1_r <= 1'b1;
      tick_sync2_r <= 1'b1;
      tick_prev_r  <= 1'b1;
      btn_prev_r   <= 1'b0;
    end else begin
      tick_sync1_r <= game_tick;
      tick_sync2_r <= tick_sync1_r;
      tick_prev_r  <= tick_sync2_r;
      btn_prev_r   <= start_btn;
    end
  end

  assign tick_rise_s   = tick_sync2_r & ~tick_prev_r;
  assign start_pulse_s = start_btn & ~btn_prev_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= GAME_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; collision beats a coincident tick in START.
  always_comb begin
    state_s       = state_r;
    enter_reset_s = 1'b0;
    end_hit_s     = 1'b0;
    case (state_r)
      GAME_INIT: begin
        if (start_pulse_s) state_s = GAME_START;
        else               state_s = GAME_INIT;
      end
      GAME_START: begin
        if (collision) begin
          state_s   = GAME_END;
          end_hit_s = 1'b1;
        end else begin
          state_s = GAME_START;
        end
      end
      GAME_END: begin
        if (start_pulse_s) begin
          state_s       = GAME_RESET;
          enter_reset_s = 1'b1;
        end else begin
          state_s = GAME_END;
        end
      end
      GAME_RESET: begin
        if (rcnt_r == RCNT_LAST) state_s = GAME_START;
        else                     state_s = GAME_RESET;
      end
      default: state_s = GAME_INIT;
    endcase
  end

  assign tick_count_s = (state_r == GAME_START) && !collision && tick_rise_s;
  assign score_inc_s  = tick_count_s && (div_r == DIV_LAST);

  // Tick divider and RESET hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r  <= '0;
      rcnt_r <= '0;
    end else begin
      if (enter_reset_s) begin
        div_r <= '0;
      end else if (tick_count_s) begin
        div_r <= (div_r == DIV_LAST) ? '0 : div_r + DIV_W'(1);
      end
      if (state_r == GAME_RESET) rcnt_r <= rcnt_r + RCNT_W'(1);
      else                       rcnt_r <= '0;
    end
  end

  // High score compares the pre-increment score on the START->END edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_score_r   <= '0;
      new_record_r <= 1'b0;
    end else if (end_hit_s) begin
      if (score_s > hi_score_r) begin
        hi_score_r   <= score_s;
        new_record_r <= 1'b1;
      end else begin
        new_record_r <= 1'b0;
      end
    end else if ((state_r == GAME_END) && (state_s != GAME_END)) begin
      new_record_r <= 1'b0;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter_reset_s),
    .inc   (score_inc_s),
    .count (score_s)
  );

  assign game_state   = state_r;
  assign score_bcd    = score_s;
  assign hi_score_bcd = hi_score_r;
  assign new_record   = new_record_r;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: table-driven scoring plus hand sequences,
// with expectations queued at stimulus time and popped when outputs are sampled.
module tb_game_state_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_tick, start_btn, collision;
  logic [1:0]  game_state;
  logic [15:0] score_bcd, hi_score_bcd;
  logic        new_record;
  // second instance with one tick per point, used to reach saturation quickly
  logic        sat_tick, sat_btn, sat_coll;
  logic [1:0]  sat_state;
  logic [15:0] sat_score, sat_hi;
  logic        sat_nr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          ticks;
    logic [15:0] score;
  } vec_t;
  vec_t vecs[5];

  localparam int S_STATE = 0, S_SCORE = 1, S_HI = 2, S_NR = 3, S_SSTATE = 4, S_SSCORE = 5;

  always #5 clk = ~clk;

  game_state_ctrl #(.TICKS_PER_POINT(8), .RESET_CYCLES(4)) dut (
    .clk (clk), .rst_n (rst_n), .game_tick (game_tick), .start_btn (start_btn),
    .collision (collision), .game_state (game_state), .score_bcd (score_bcd),
    .hi_score_bcd (hi_score_bcd), .new_record (new_record)
  );

  game_state_ctrl #(.TICKS_PER_POINT(1), .RESET_CYCLES(4)) sat (
    .clk (clk), .rst_n (rst_n), .game_tick (sat_tick), .start_btn (sat_btn),
    .collision (sat_coll), .game_state (sat_state), .score_bcd (sat_score),
    .hi_score_bcd (sat_hi), .new_record (sat_nr)
  );

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_STATE:  return {14'd0, game_state};
      S_SCORE:  return score_bcd;
      S_HI:     return hi_score_bcd;
      S_NR:     return {15'd0, new_record};
      S_SSTATE: return {14'd0, sat_state};
      S_SSCORE: return sat_score;
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = observe(e.sel);
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", e.tag, act, e.exp, $time);
      end
    end
  endtask

  task automatic pulse_ticks(input int n, input bit on_sat);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (on_sat) sat_tick = 1'b0; else game_tick = 1'b0;
      @(negedge clk);
      if (on_sat) sat_tick = 1'b1; else game_tick = 1'b1;
    end
  endtask

  // Press start in END and walk the RESET hold back into START.
  task automatic reset_seq(input string tag, input logic [15:0] hi);
    @(negedge clk) start_btn = 1'b1;
    @(posedge clk); #1;
    expect_val({tag, "_enter_state"}, S_STATE, 16'(GAME_RESET));
    expect_val({tag, "_enter_score"}, S_SCORE, 16'h0000);
    expect_val({tag, "_enter_nr"}, S_NR, 16'h0000);
    expect_val({tag, "_enter_hi"}, S_HI, hi);
    check_all();
    @(negedge clk) start_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_val({tag, "_hold_state"}, S_STATE, 16'(GAME_RESET));
      check_all();
    end
    @(posedge clk); #1;
    expect_val({tag, "_exit_state"}, S_STATE, 16'(GAME_START));
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ticks: 7,  score: 16'h0000};
    vecs[1] = '{ticks: 1,  score: 16'h0001};
    vecs[2] = '{ticks: 8,  score: 16'h0002};
    vecs[3] = '{ticks: 56, score: 16'h0009};
    vecs[4] = '{ticks: 8,  score: 16'h0010};

    rst_n = 1'b0; start_btn = 1'b0; game_tick = 1'b1; collision = 1'b0;
    sat_btn = 1'b1; sat_tick = 1'b1; sat_coll = 1'b0;
    repeat (3) @(posedge clk); #1;
    expect_val("rst_state", S_STATE, 16'(GAME_INIT));
    expect_val("rst_score", S_SCORE, 16'h0000);
    expect_val("rst_hi", S_HI, 16'h0000);
    expect_val("rst_nr", S_NR, 16'h0000);
    check_all();

    // game_tick high across release must not count; sat enters START immediately
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    expect_val("idle_state", S_STATE, 16'(GAME_INIT));
    expect_val("sat_release_state", S_SSTATE, 16'(GAME_START));
    expect_val("sat_release_no_tick", S_SSCORE, 16'h0000);
    check_all();

    pulse_ticks(9998, 1'b1);
    repeat (4) @(posedge clk); #1;
    expect_val("sat_9998", S_SSCORE, 16'h9998);
    check_all();
    pulse_ticks(1, 1'b1);
    repeat (4) @(posedge clk); #1;
    expect_val("sat_9999", S_SSCORE, 16'h9999);
    check_all();
    pulse_ticks(8, 1'b1);
    repeat (4) @(posedge clk); #1;
    expect_val("sat_no_wrap", S_SSCORE, 16'h9999);
    check_all();

    // start held 100 clks gives one INIT->START, next clk
    @(negedge clk) start_btn = 1'b1;
    @(posedge clk); #1;
    expect_val("start_state", S_STATE, 16'(GAME_START));
    check_all();
    repeat (99) @(posedge clk); #1;
    expect_val("start_held_state", S_STATE, 16'(GAME_START));
    expect_val("start_held_score", S_SCORE, 16'h0000);
    check_all();
    @(negedge clk) start_btn = 1'b0;

    for (int v = 0; v < 5; v++) begin
      pulse_ticks(vecs[v].ticks, 1'b0);
      expect_val($sformatf("vec%0d_score", v), S_SCORE, vecs[v].score);
      repeat (4) @(posedge clk); #1;
      check_all();
    end

    // increment lands on the 3rd clk after the 8th input edge
    pulse_ticks(7, 1'b0);
    @(negedge clk) game_tick = 1'b0;
    @(negedge clk) game_tick = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    expect_val("latency_before", S_SCORE, 16'h0010);
    check_all();
    @(posedge clk); #1;
    expect_val("latency_at3", S_SCORE, 16'h0011);
    check_all();

    pulse_ticks(248, 1'b0);
    repeat (4) @(posedge clk); #1;
    expect_val("run1_score", S_SCORE, 16'h0042);
    check_all();
    @(negedge clk) collision = 1'b1;
    @(posedge clk); #1;
    expect_val("run1_end_state", S_STATE, 16'(GAME_END));
    expect_val("run1_hi", S_HI, 16'h0042);
    expect_val("run1_nr", S_NR, 16'h0001);
    check_all();
    @(negedge clk) collision = 1'b0;

    reset_seq("run2", 16'h0042);
    pulse_ticks(136, 1'b0);
    repeat (4) @(posedge clk); #1;
    expect_val("run2_score", S_SCORE, 16'h0017);
    check_all();

    // collision in the same cycle as the 8th tick_rise
    pulse_ticks(7, 1'b0);
    @(negedge clk) game_tick = 1'b0;
    @(negedge clk) game_tick = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk) collision = 1'b1;
    @(posedge clk); #1;
    expect_val("coinc_state", S_STATE, 16'(GAME_END));
    expect_val("coinc_score", S_SCORE, 16'h0017);
    expect_val("run2_hi", S_HI, 16'h0042);
    expect_val("run2_nr", S_NR, 16'h0000);
    check_all();

    // collision still high on entry to START -> END next clk
    reset_seq("run3", 16'h0042);
    @(posedge clk); #1;
    expect_val("coll_entry_state", S_STATE, 16'(GAME_END));
    expect_val("coll_entry_nr", S_NR, 16'h0000);
    expect_val("coll_entry_hi", S_HI, 16'h0042);
    check_all();
    @(negedge clk) collision = 1'b0;

    reset_seq("run4", 16'h0042);
    pulse_ticks(8, 1'b0);
    repeat (4) @(posedge clk); #1;
    expect_val("run4_score", S_SCORE, 16'h0001);
    check_all();

    // asynchronous reset mid-START, observed before any clock edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    expect_val("async_state", S_STATE, 16'(GAME_INIT));
    expect_val("async_score", S_SCORE, 16'h0000);
    expect_val("async_hi", S_HI, 16'h0000);
    expect_val("async_nr", S_NR, 16'h0000);
    check_all();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
